// File: rtl/edge_detect_pipe_if.sv
// edge_detect_pipe_if: video input, runtime control and overlay output signals of edge_detect_pipe.
interface edge_detect_pipe_if;
  logic [23:0] rgb;
  logic [23:0] rgb1;
  logic [10:0] hcount;
  logic [9:0] vcount;
  logic pix_valid;
  logic [1:0] mode;
  logic [7:0] threshold;
  logic [23:0] edgeoutputsel;
  logic out_valid;
  logic select;
  modport master (
    output rgb, rgb1, hcount, vcount, pix_valid, mode, threshold,
    input edgeoutputsel, out_valid, select
  );
  modport slave (
    input rgb, rgb1, hcount, vcount, pix_valid, mode, threshold,
    output edgeoutputsel, out_valid, select
  );
endinterface

// File: rtl/edge_detect_pipe.sv
// edge_detect_pipe: 5-stage Sobel pipeline (gray, 3x3 window over two line buffers, gradients, magnitude, mode mux).
// Define EDGE_COLOR_EN to paint mode-3 edge pixels with EDGE_RGB instead of white.
module edge_detect_pipe #(
  parameter int COLS = 640,
  parameter logic [23:0] EDGE_RGB = 24'hFF0000
) (
  input logic clock,
  input logic reset,
  edge_detect_pipe_if.slave bus
);
  localparam int aw = $clog2(COLS);
`ifdef EDGE_COLOR_EN
  localparam logic [23:0] edge_c = EDGE_RGB;
`else
  localparam logic [23:0] edge_c = EDGE_RGB | 24'hFFFFFF;
`endif
  logic [23:0] px;
  logic [15:0] gsum;
  logic [7:0] gray, g1, g3, d3, g4, d4, m4;
  logic [7:0] lb0 [COLS];
  logic [7:0] lb1 [COLS];
  logic [2:0][7:0] w0, w1, w2;
  logic [aw-1:0] col, col_e;
  logic [1:0] row, row_e;
  logic v1, v2, v3, v4, fs1, b2, b3, wrap;
  logic [9:0] sx_r, sx_l, sy_t, sy_b;
  logic signed [10:0] gx, gy;
  logic [10:0] ax, ay;
  logic [11:0] mag;
  assign px = bus.hcount[0] ? bus.rgb : bus.rgb1;
  assign gsum = 16'd77 * {8'd0, px[23:16]} + 16'd150 * {8'd0, px[15:8]} + 16'd29 * {8'd0, px[7:0]};
  assign gray = 8'(gsum >> 8);
  // A frame-start pixel lands at column 0 of row 0 regardless of where the counters were
  assign col_e = fs1 ? '0 : col;
  assign row_e = fs1 ? '0 : row;
  assign wrap = col_e == aw'(COLS - 1);
  // Window index 0 is the newest column; w0 is the current line, w2 the oldest
  assign sx_r = {2'd0, w0[0]} + {1'b0, w1[0], 1'b0} + {2'd0, w2[0]};
  assign sx_l = {2'd0, w0[2]} + {1'b0, w1[2], 1'b0} + {2'd0, w2[2]};
  assign sy_t = {2'd0, w2[0]} + {1'b0, w2[1], 1'b0} + {2'd0, w2[2]};
  assign sy_b = {2'd0, w0[0]} + {1'b0, w0[1], 1'b0} + {2'd0, w0[2]};
  assign ax = gx[10] ? 11'(-gx) : gx;
  assign ay = gy[10] ? 11'(-gy) : gy;
  assign mag = {1'b0, ax} + {1'b0, ay};
  always_ff @(posedge clock) begin
    g1 <= gray;
    fs1 <= bus.pix_valid && bus.hcount == '0 && bus.vcount == '0;
    if (v1) begin
      lb0[col_e] <= g1;
      lb1[col_e] <= lb0[col_e];
      w0 <= {w0[1:0], g1};
      w1 <= {w1[1:0], lb0[col_e]};
      w2 <= {w2[1:0], lb1[col_e]};
      b2 <= row_e < 2'd2 || col_e < aw'(2);
    end
    gx <= $signed({1'b0, sx_r}) - $signed({1'b0, sx_l});
    gy <= $signed({1'b0, sy_t}) - $signed({1'b0, sy_b});
    g3 <= w1[1];
    d3 <= w2[2];
    b3 <= b2;
    g4 <= g3;
    d4 <= d3;
    m4 <= b3 ? 8'd0 : (|mag[11:8] ? 8'hFF : mag[7:0]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      {v1, v2, v3, v4} <= '0;
      col <= '0;
      row <= '0;
      bus.out_valid <= 1'b0;
      bus.select <= 1'b0;
      bus.edgeoutputsel <= '0;
    end else begin
      v1 <= bus.pix_valid;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      if (v1) begin
        col <= wrap ? '0 : col_e + 1'b1;
        row <= (wrap && row_e != 2'd2) ? row_e + 1'b1 : row_e;
      end
      bus.out_valid <= v4;
      bus.select <= v4 && (bus.mode != 2'd3 || m4 > bus.threshold);
      if (v4)
        bus.edgeoutputsel <= bus.mode == 2'd0 ? {3{g4}} :
                             bus.mode == 2'd1 ? {3{d4}} :
                             bus.mode == 2'd2 ? {3{m4}} :
                             (m4 > bus.threshold ? edge_c : 24'h0);
    end
  end
endmodule

// File: tb/tb_edge_detect_pipe.sv
// tb_edge_detect_pipe: scoreboard bench for edge_detect_pipe (COLS=8) driven by directed images.
// Expected pixels come from a frame-level Sobel reference over the image the bench itself sent.
module tb_edge_detect_pipe;
  localparam int COLS = 8;
`ifdef EDGE_COLOR_EN
  localparam logic [23:0] EC = 24'hFF0000;
`else
  localparam logic [23:0] EC = 24'hFFFFFF;
`endif
  typedef struct packed {
    logic [23:0] d;
    logic s;
    logic k;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  edge_detect_pipe_if bus ();
  edge_detect_pipe #(.COLS(COLS)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  exp_t q[$];
  int img [int];
  int ln = 0, c = 0, n_cmp = 0, n_bad = 0, lat;
  bit chk_hold = 1'b0;
  logic [23:0] held = '0;

  function automatic int px_at(int y, int x);
    return img[y * COLS + x];
  endfunction

  function automatic int sob(int y, int x);
    int gx, gy, m;
    gx = 0;
    gy = 0;
    for (int d = -1; d <= 1; d++) begin
      gx += (d == 0 ? 2 : 1) * (px_at(y + d, x + 1) - px_at(y + d, x - 1));
      gy += (d == 0 ? 2 : 1) * (px_at(y - 1, x + d) - px_at(y + 1, x + d));
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return m > 255 ? 255 : m;
  endfunction

  task automatic send(input logic [23:0] px, input int g, input bit fs);
    exp_t e;
    int m;
    if (fs) begin
      ln = 0;
      c = 0;
    end
    bus.hcount = 11'(c);
    bus.vcount = fs ? 10'd0 : 10'(ln);
    bus.rgb = c[0] ? px : ~px;
    bus.rgb1 = c[0] ? ~px : px;
    bus.pix_valid = 1'b1;
    img[ln * COLS + c] = g;
    m = (ln >= 2 && c >= 2) ? sob(ln - 1, c - 1) : 0;
    e.s = 1'b1;
    e.k = 1'b1;
    e.d = {3{8'(m)}};
    if (bus.mode == 2'd0) begin
      e.k = ln >= 1 && c >= 1;
      if (e.k) e.d = {3{8'(px_at(ln - 1, c - 1))}};
    end else if (bus.mode == 2'd1) begin
      e.k = ln >= 2 && c >= 2;
      if (e.k) e.d = {3{8'(px_at(ln - 2, c - 2))}};
    end else if (bus.mode == 2'd3) begin
      e.s = m > int'(bus.threshold);
      e.d = e.s ? EC : 24'h0;
    end
    q.push_back(e);
    if (c == COLS - 1) begin
      c = 0;
      ln++;
    end else c++;
    @(posedge clock); #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic gsend(input int g, input bit fs);
    send({3{8'(g)}}, g, fs);
  endtask

  task automatic step(input int hi, input bit fs);
    int cc;
    cc = fs ? 0 : c;
    gsend(cc >= 4 ? hi : 0, fs);
  endtask

  task automatic idle();
    bus.pix_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d outputs still pending, want 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_rst(input string nm);
    n_cmp += 3;
    if (bus.edgeoutputsel !== 24'h0) begin
      n_bad++;
      $display("FAIL %s edgeoutputsel: got %h want 000000", nm, bus.edgeoutputsel);
    end
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s out_valid: got %b want 0", nm, bus.out_valid);
    end
    if (bus.select !== 1'b0) begin
      n_bad++;
      $display("FAIL %s select: got %b want 0", nm, bus.select);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.out_valid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_out: got pix=%h with no pending pixel, want none", bus.edgeoutputsel);
        end else begin
          e = q.pop_front();
          if (bus.select !== e.s || (e.k && bus.edgeoutputsel !== e.d)) begin
            n_bad++;
            $display("FAIL out: got pix=%h sel=%b, want pix=%h sel=%b (pix checked=%b)",
                     bus.edgeoutputsel, bus.select, e.d, e.s, e.k);
          end
        end
        held = bus.edgeoutputsel;
      end else if (chk_hold) begin
        n_cmp++;
        if (bus.edgeoutputsel !== held || bus.select !== 1'b0) begin
          n_bad++;
          $display("FAIL bubble_hold: got pix=%h sel=%b, want pix=%h sel=0", bus.edgeoutputsel, bus.select, held);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rgb = '0;
    bus.rgb1 = '0;
    bus.hcount = '0;
    bus.vcount = '0;
    bus.pix_valid = 1'b0;
    bus.mode = 2'd0;
    bus.threshold = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    check_rst("reset_state");
    reset = 1'b0;
    // Gray conversion: odd columns take rgb (red), even columns take rgb1 (green)
    for (int i = 0; i < 3 * COLS + 3; i++)
      send(i[0] ? 24'hFF0000 : 24'h00FF00, i[0] ? 'h4C : 'h95, i == 0);
    // Reset with pixels still in flight
    reset = 1'b1;
    @(posedge clock); #1;
    check_rst("reset_mid");
    q.delete();
    ln = 0;
    c = 0;
    reset = 1'b0;
    lat = 1;
    gsend('h20, 1'b0);
    while (bus.out_valid !== 1'b1 && lat < 12) begin
      @(posedge clock); #1;
      lat++;
    end
    n_cmp++;
    if (lat != 5) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, want 5", lat);
    end
    drain();
    // Two-line-delay view of a non-repeating image
    bus.mode = 2'd1;
    for (int i = 0; i < 3 * COLS; i++) gsend((i * 37 + 11) & 255, i == 0);
    drain();
    // Flat image: magnitude zero everywhere
    bus.mode = 2'd2;
    for (int i = 0; i < 4 * COLS; i++) gsend(100, i == 0);
    drain();
    // Vertical 0/255 step saturates on the step columns
    for (int i = 0; i < 4 * COLS; i++) step(255, i == 0);
    drain();
    // Threshold boundary: step of 10 gives magnitude 40
    bus.mode = 2'd3;
    bus.threshold = 8'd40;
    for (int i = 0; i < 3 * COLS; i++) step(10, i == 0);
    drain();
    bus.threshold = 8'd39;
    for (int i = 0; i < 3 * COLS; i++) step(10, i == 0);
    drain();
    // Bubbles every third cycle, then a frame restart in the middle of a line
    bus.mode = 2'd2;
    chk_hold = 1'b1;
    for (int i = 0; i < 3 * COLS + 3; i++) begin
      if (i % 3 == 2) idle();
      step(255, i == 0);
    end
    for (int i = 0; i < 3 * COLS; i++) begin
      if (i % 3 == 2) idle();
      step(255, i == 0);
    end
    drain();
    chk_hold = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/edge_detect_pipe.md
Name: edge_detect_pipe

Overview:
Parametrised Sobel edge-detection pipeline for the video path. It takes two RGB pixels per ZBT word, selects one per cycle by hcount[0], and converts it to 8-bit gray. It buffers two full lines to form a 3x3 window and computes the saturated Sobel magnitude. Output is one of four runtime modes, with a select flag for the display overlay mux.

Parameters:
COLS, 640, active pixels per line; line-buffer depth (range 4..2047)
EDGE_RGB, 24'hFF0000, edge colour for mode 3; used only when EDGE_COLOR_EN is defined

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rgb  in  24  lower ZBT pixel {R,G,B}
rgb1  in  24  higher ZBT pixel {R,G,B}
hcount  in  11  horizontal pixel count
vcount  in  10  vertical line count
pix_valid  in  1  current pixel is an active-area pixel
mode  in  2  0=gray, 1=line-delayed gray, 2=Sobel magnitude, 3=binary edge
threshold  in  8  binary edge threshold
edgeoutputsel  out  24  output pixel {R,G,B}
out_valid  out  1  edgeoutputsel is valid this cycle
select  out  1  overlay select for the display mux

Behaviour:
- Reset and clocking: one clock domain; reset is synchronous and active-high. Port names are clock and reset.
- Reset values: edgeoutputsel=0, out_valid=0, select=0. Column counter, row counter and all pipeline valid bits are cleared to 0. Line-buffer RAM is not cleared.
- Pixel selection (S0, combinational):
  - hcount[0]=1 uses rgb; hcount[0]=0 uses rgb1.
- Stage S1, gray conversion (registered):
  - gray = (77*R + 150*G + 29*B) >> 8, computed in a 16-bit intermediate.
  - Maximum result is 255; no saturation is needed.
- Stage S2, window update (only when the pipeline valid bit is set):
  - Shift the gray value into row 0 of the window.
  - Each line buffer is read at the column address and written in the same cycle (read-before-write). Its output feeds window rows 1 and 2.
  - The column counter increments and wraps at COLS-1 to 0.
  - On wrap, the row counter increments, saturating at 2.
- Frame start: pix_valid with hcount==0 and vcount==0 forces the column and row counters to 0 before the increment. This pixel is written at column 0.
- Stage S3, gradients:
  - Gx and Gy use the standard Sobel kernels, 11-bit signed.
- Stage S4, magnitude:
  - mag = |Gx| + |Gy|, 12-bit, saturated to 255.
- Stage S5, mode mux (registered), driving the outputs:
  - mode 0: {g,g,g}, where g is the window centre pixel.
  - mode 1: {d,d,d}, where d is the row-2 oldest tap (two-line-delay debug view).
  - mode 2: {m,m,m} with m = saturated magnitude.
  - mode 3: 24'hFFFFFF if mag > threshold, else 0. The comparison is strict; mag==threshold gives 0.
- Latency: out_valid goes high exactly 5 cycles after a pix_valid cycle. Output pixel position is (row-1, col-1) relative to the input pixel.
- Border suppression: while the row counter < 2, or column counter < 2 at S2, modes 2 and 3 output 0. out_valid still asserts.
- select:
  - mode 3: out_valid AND mag > threshold.
  - other modes: equal to out_valid.
- Gaps: pix_valid=0 stalls nothing. Bubbles propagate, out_valid=0 in those cycles, and edgeoutputsel holds its last value.
- mode and threshold are sampled at S4/S5. A change takes effect on the next output and never glitches within a cycle.
- Reset mid-frame: the pipeline flushes. The next frame start or the next COLS valid pixels rebuild the window, with border suppression applied.

Optional Feature:
EDGE_COLOR_EN
- Defined: mode 3 outputs EDGE_RGB on edge pixels instead of 24'hFFFFFF. Non-edge pixels remain 0 and select is unchanged.
- Undefined: EDGE_RGB is unused and edge pixels are white.

Test Plan:
1. Reset and pipe latency (COLS=8): assert reset mid-stream.
   -> Next cycle: all outputs 0, counters 0.
   -> First pix_valid after release produces out_valid exactly 5 cycles later.
2. Gray conversion in mode 0: rgb=24'hFF0000 with hcount odd, rgb1=24'h00FF00 with hcount even.
   -> Outputs alternate 24'h4C4C4C and 24'h959595.
3. Flat image in mode 2: 3 lines of constant gray 100, COLS=8.
   -> Magnitude 0 everywhere.
   -> Rows 0-1 and columns 0-1 are 0 via border suppression.
4. Vertical step in mode 2: columns 0-3 gray 0, columns 4-7 gray 255.
   -> Step-column outputs saturate to 24'hFFFFFF (raw 1020).
   -> Flat regions output 0.
5. Threshold boundary in mode 3: build a window with mag=40.
   -> threshold=40 gives 0 and select=0.
   -> threshold=39 gives 24'hFFFFFF (EDGE_RGB if EDGE_COLOR_EN) and select=1.
6. Gaps and frame restart: insert pix_valid=0 bubbles every 3rd cycle, then a new frame start mid-line.
   -> Outputs are identical to the gapless run.
   -> Row counter restarts and two lines are border-suppressed.
